// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, HI, LO, WR, CSUM, DONE, ERR} state_t;
  localparam logic [15:0] HALT_DEFAULT = 16'hFFFF;
  localparam int          WORD_BYTES   = 2;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input handshake plus instruction-memory write bus.
interface imem_loader_if #(parameter int ADDR_W = 16);
  import imem_loader_pkg::*;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;

  modport master (input in_valid, in_data, output in_ready, mem_we, mem_addr, mem_wdata);
  modport slave  (output in_valid, in_data, input in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs byte pairs into a 16-bit word, high byte first.
// With CHECKSUM_EN defined, also keeps a mod-256 running sum of the loaded bytes.
module word_assembler (
  input  logic        clock,
  input  logic        reset_n,
`ifdef CHECKSUM_EN
  input  logic        clr,
  output logic        csum_ok,
`endif
  input  logic        hi_en,
  input  logic        lo_en,
  input  logic [7:0]  data,
  output logic [15:0] word
);
  logic [7:0] hi_q, lo_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= 8'h00;
      lo_q <= 8'h00;
    end else begin
      if (hi_en) hi_q <= data;
      if (lo_en) lo_q <= data;
    end
  end

  assign word = {hi_q, lo_q};

`ifdef CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] neg_sum;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)            sum_q <= 8'h00;
    else if (clr)            sum_q <= 8'h00;
    else if (hi_en || lo_en) sum_q <= sum_q + data;
  end

  // The trailing byte must cancel the sum of everything before it.
  assign neg_sum = 8'd0 - sum_q;
  assign csum_ok = (data == neg_sum);
`endif
endmodule

// File: rtl/imem_loader.sv
// Streams byte pairs into instruction memory and holds the CPU in reset until
// the halt word lands. Optional trailing checksum byte: define CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter int          MAX_WORDS = 256,
  parameter logic [15:0] HALT_WORD = HALT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  imem_loader_if.master     bus,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] word_count
);
  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, count_q;
  logic [15:0]       word;
  logic              xfer, restart, hi_en, lo_en, last_slot;

  assign xfer      = bus.in_valid & bus.in_ready;
  assign restart   = start & (state_q inside {IDLE, DONE, ERR});
  assign hi_en     = xfer & (state_q == HI);
  assign lo_en     = xfer & (state_q == LO);
  assign last_slot = ({1'b0, count_q} + 1'b1) == MAX_CNT;

`ifdef CHECKSUM_EN
  logic csum_ok;
  word_assembler u_asm (
    .clock, .reset_n, .clr(restart), .csum_ok,
    .hi_en, .lo_en, .data(bus.in_data), .word
  );
`else
  word_assembler u_asm (
    .clock, .reset_n,
    .hi_en, .lo_en, .data(bus.in_data), .word
  );
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: if (start) state_d = HI;
      HI:              if (xfer)  state_d = LO;
      LO:              if (xfer)  state_d = WR;
      WR: begin
`ifdef CHECKSUM_EN
        if (word == HALT_WORD)  state_d = CSUM;
`else
        if (word == HALT_WORD)  state_d = DONE;
`endif
        else if (last_slot)     state_d = ERR;
        else                    state_d = HI;
      end
`ifdef CHECKSUM_EN
      CSUM:            if (xfer)  state_d = csum_ok ? DONE : ERR;
`endif
      default:                    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      count_q <= '0;
    end else if (restart) begin
      addr_q  <= '0;
      count_q <= '0;
    end else if (state_q == WR) begin
      addr_q  <= addr_q + ADDR_W'(WORD_BYTES);
      count_q <= count_q + 1'b1;
    end
  end

`ifdef CHECKSUM_EN
  assign bus.in_ready = state_q inside {HI, LO, CSUM};
`else
  assign bus.in_ready = state_q inside {HI, LO};
`endif
  assign bus.mem_we    = (state_q == WR);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = word;
  assign done          = (state_q == DONE);
  assign err           = (state_q == ERR);
  assign cpu_hold      = (state_q != DONE);
  assign word_count    = count_q;
endmodule
